// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the arbiter's buses. These are the write-back request bus, the
//   register-file write port, the issue-stage allocation handshake and the
//   scoreboard status.
//   Modports:
//     slave  - the arbiter. Its inputs are the requests and the issue
//              allocation. Its outputs are the grants, the register-file write
//              port, issue_ready, pending and sb_err.
//     master - the surrounding pipeline, the mirror image of slave.
//   Parameter NREQ: number of write-back requesters.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*5-1:0]  req_reg;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               RegWrite;
    logic [4:0]         writeReg;
    logic [31:0]        writeData;
    logic               issue_valid;
    logic [4:0]         issue_reg;
    logic               issue_ready;
    logic [31:0]        pending;
    logic               sb_err;

    modport slave (
        input  req_valid, req_reg, req_data, issue_valid, issue_reg,
        output req_ready, RegWrite, writeReg, writeData, issue_ready, pending, sb_err
    );

    modport master (
        output req_valid, req_reg, req_data, issue_valid, issue_reg,
        input  req_ready, RegWrite, writeReg, writeData, issue_ready, pending, sb_err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Grants one of NREQ write-back requesters per cycle and drives the single
//   register-file write port from registered outputs. The write reaches the
//   register file one cycle after the handshake.
//   It also keeps a CNTW-bit outstanding-write counter for each of r1..r31,
//   so that the issue stage can stall on hazards.
//   Ports:
//     clk - system clock, rising edge.
//     rst - asynchronous active-high reset.
//     bus - regfile_wb_arbiter_if.slave, which carries:
//           - the requests and grants,
//           - RegWrite, writeReg and writeData,
//           - issue_valid, issue_reg and issue_ready,
//           - pending and sb_err.
//   Configuration macro RR_ARB_EN:
//     defined   - round-robin arbitration. The search starts at the pointer.
//     undefined - fixed priority. The lowest requester index wins.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int CNTW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NREQ);
    localparam logic [CNTW-1:0] CMAX = '1;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            gany;
    logic [4:0]      sel_reg;
    logic [31:0]     sel_data;

    logic            wb_en;
    logic [4:0]      wb_reg;
    logic [31:0]     wb_data;

    logic [CNTW-1:0] cnt [32];
    logic [31:0]     inc_vec;
    logic [31:0]     dec_vec;
    logic            dec_hit;
    logic            issue_rdy;
    logic            issue_fire;
    logic [31:0]     pend;

`ifdef RR_ARB_EN
    logic [PW-1:0] ptr;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        gidx  = '0;
        gany  = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            // Wrap ptr+off back into 0..NREQ-1 without a modulo operator.
            sum = {1'b0, ptr} + (PW+1)'(off);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!gany && bus.req_valid[idx]) begin
                gany = 1'b1;
                gidx = idx;
            end
        end
        if (gany) begin
            grant[gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gany) begin
            ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
        end
    end
`else
    always_comb begin
        grant = '0;
        gidx  = '0;
        gany  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gany && bus.req_valid[i]) begin
                gany = 1'b1;
                gidx = PW'(i);
            end
        end
        if (gany) begin
            grant[gidx] = 1'b1;
        end
    end
`endif

    // No grant can be seen while reset is held, so nothing is consumed.
    assign bus.req_ready = grant & {NREQ{~rst}};

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == PW'(i)) begin
                sel_reg  = bus.req_reg[5*i +: 5];
                sel_data = bus.req_data[32*i +: 32];
            end
        end
    end

    // A request for r0 is consumed, but it never reaches the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_reg  <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= gany && (sel_reg != 5'd0);
            if (gany) begin
                wb_reg  <= sel_reg;
                wb_data <= sel_data;
            end
        end
    end

    assign bus.RegWrite  = wb_en;
    assign bus.writeReg  = wb_reg;
    assign bus.writeData = wb_data;

    // A saturated counter can still accept an issue when the write that
    // commits this edge is for the same register, because the two cancel.
    assign dec_hit     = wb_en && (wb_reg == bus.issue_reg);
    assign issue_rdy   = (bus.issue_reg == 5'd0) || (cnt[bus.issue_reg] != CMAX) || dec_hit;
    assign issue_fire  = bus.issue_valid && issue_rdy && (bus.issue_reg != 5'd0);
    assign bus.issue_ready = issue_rdy;

    assign inc_vec = issue_fire ? (32'd1 << bus.issue_reg) : '0;
    assign dec_vec = wb_en ? (32'd1 << wb_reg) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
            bus.sb_err <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
            // A write-back that finds no outstanding allocation is recorded
            // until the next reset.
            if (wb_en && cnt[wb_reg] == '0) begin
                bus.sb_err <= 1'b1;
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int r = 1; r < 32; r++) begin
            pend[r] = (cnt[r] != '0);
        end
    end

    assign bus.pending = pend;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int CNTW = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ)) bus();

    regfile_wb_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [2:0] v;
        logic [2:0] exp;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[11];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Wait for the negedge, then check the write port against the scoreboard.
    task automatic neg();
        bit want;
        @(negedge clk);
        if (!rst) begin
            want = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, want});
            if (want) begin
                chk("writeReg", {27'd0, bus.writeReg}, {27'd0, exp_q[0].r});
                chk("writeData", bus.writeData, exp_q[0].d);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic pos();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Drive requests, check the grant at the negedge, and queue the write it implies.
    task automatic req_cycle(input logic [2:0] v, input logic [14:0] regs,
                             input logic [95:0] data, input logic [2:0] exp,
                             input string name);
        wr_t w;
        bus.req_valid = v;
        bus.req_reg   = regs;
        bus.req_data  = data;
        neg();
        chk(name, {29'd0, bus.req_ready}, {29'd0, exp});
        for (int k = 0; k < NREQ; k++) begin
            if (exp[k] && regs[5*k +: 5] != 5'd0) begin
                w.cyc = cyc + 1;
                w.r   = regs[5*k +: 5];
                w.d   = data[32*k +: 32];
                exp_q.push_back(w);
            end
        end
    endtask

    initial begin
`ifdef RR_ARB_EN
        tbl = '{'{3'b111, 3'b001}, '{3'b111, 3'b010}, '{3'b111, 3'b100},
                '{3'b111, 3'b001}, '{3'b111, 3'b010}, '{3'b111, 3'b100},
                '{3'b110, 3'b010}, '{3'b011, 3'b001}, '{3'b000, 3'b000},
                '{3'b101, 3'b100}, '{3'b100, 3'b100}};
`else
        tbl = '{'{3'b111, 3'b001}, '{3'b111, 3'b001}, '{3'b111, 3'b001},
                '{3'b111, 3'b001}, '{3'b111, 3'b001}, '{3'b111, 3'b001},
                '{3'b110, 3'b010}, '{3'b011, 3'b001}, '{3'b000, 3'b000},
                '{3'b101, 3'b001}, '{3'b100, 3'b100}};
`endif
        rst = 1'b1;
        bus.req_valid   = 3'b111;
        bus.req_reg     = {5'd3, 5'd2, 5'd1};
        bus.req_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_reg   = 5'd5;

        // Reset values, with requests asserted while reset is held.
        neg();
        chk("rst_req_ready", {29'd0, bus.req_ready}, 32'd0);
        chk("rst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("rst_writeReg", {27'd0, bus.writeReg}, 32'd0);
        chk("rst_writeData", bus.writeData, 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_sb_err", {31'd0, bus.sb_err}, 32'd0);
        pos();
        rst = 1'b0;
        bus.req_valid = 3'b000;
        neg();
        chk("issue_ready_after_rst", {31'd0, bus.issue_ready}, 32'd1);
        pos();

        // Single write to r5.
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd5;
        neg();
        chk("issue_ready_r5", {31'd0, bus.issue_ready}, 32'd1);
        chk("pending5_pre", {31'd0, bus.pending[5]}, 32'd0);
        pos();
        bus.issue_valid = 1'b0;
        req_cycle(3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 3'b001, "ready_single");
        chk("pending5_set", {31'd0, bus.pending[5]}, 32'd1);
        pos();
        bus.req_valid = 3'b000;
        neg();
        chk("pending5_during_write", {31'd0, bus.pending[5]}, 32'd1);
        pos();
        neg();
        chk("pending5_clear", {31'd0, bus.pending[5]}, 32'd0);
        chk("sb_err_single", {31'd0, bus.sb_err}, 32'd0);
        pos();

        // Saturate r7, then issue in the same cycle as a write to r7.
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd7;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("issue_ready_r7", {31'd0, bus.issue_ready}, 32'd1);
            pos();
        end
        neg();
        chk("issue_ready_sat", {31'd0, bus.issue_ready}, 32'd0);
        chk("pending7_sat", {31'd0, bus.pending[7]}, 32'd1);
        pos();
        req_cycle(3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 32'h77770001}, 3'b001, "ready_r7");
        chk("issue_ready_sat_nowr", {31'd0, bus.issue_ready}, 32'd0);
        pos();
        bus.req_valid = 3'b000;
        neg();
        chk("issue_ready_with_dec", {31'd0, bus.issue_ready}, 32'd1);
        pos();
        neg();
        chk("issue_ready_still_sat", {31'd0, bus.issue_ready}, 32'd0);
        pos();
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_cycle(3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 32'h77770010 + 32'(i)}, 3'b001, "ready_drain");
            pos();
        end
        bus.req_valid = 3'b000;
        neg();
        chk("pending7_last", {31'd0, bus.pending[7]}, 32'd1);
        pos();
        neg();
        chk("pending7_clear", {31'd0, bus.pending[7]}, 32'd0);
        chk("sb_err_drain", {31'd0, bus.sb_err}, 32'd0);
        pos();

        // A write to r0 is consumed silently. A write to r9 with no allocation raises sb_err.
        req_cycle(3'b001, {5'd0, 5'd0, 5'd0}, {64'd0, 32'h0BAD0000}, 3'b001, "ready_r0");
        pos();
        bus.req_valid = 3'b000;
        neg();
        chk("sb_err_r0", {31'd0, bus.sb_err}, 32'd0);
        pos();
        req_cycle(3'b001, {5'd0, 5'd0, 5'd9}, {64'd0, 32'h00000099}, 3'b001, "ready_r9");
        pos();
        bus.req_valid = 3'b000;
        neg();
        chk("sb_err_before", {31'd0, bus.sb_err}, 32'd0);
        pos();
        neg();
        chk("sb_err_set", {31'd0, bus.sb_err}, 32'd1);
        chk("pending_zero", bus.pending, 32'd0);
        pos();
        pos();
        pos();
        neg();
        chk("sb_err_sticky", {31'd0, bus.sb_err}, 32'd1);
        pos();

        // Reset asserted in the middle of a cycle with RegWrite high.
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd20;
        req_cycle(3'b001, {5'd0, 5'd0, 5'd12}, {64'd0, 32'hC0FFEE12}, 3'b001, "ready_r12");
        pos();
        bus.issue_valid = 1'b0;
        bus.req_valid   = 3'b000;
        neg();
        chk("pending20_before_rst", {31'd0, bus.pending[20]}, 32'd1);
        #2;
        rst = 1'b1;
        bus.req_valid = 3'b111;
        exp_q.delete();
        #1;
        chk("midrst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("midrst_writeReg", {27'd0, bus.writeReg}, 32'd0);
        chk("midrst_writeData", bus.writeData, 32'd0);
        chk("midrst_pending", bus.pending, 32'd0);
        chk("midrst_sb_err", {31'd0, bus.sb_err}, 32'd0);
        chk("midrst_req_ready", {29'd0, bus.req_ready}, 32'd0);
        pos();
        rst = 1'b0;
        bus.req_valid = 3'b000;
        bus.issue_reg = 5'd20;
        neg();
        chk("midrst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
        pos();

        // Table of arbitration patterns. The pointer is 0 after the reset above.
        for (int v = 0; v < 11; v++) begin
            req_cycle(tbl[v].v, {5'd12, 5'd11, 5'd10},
                      {32'hA2000000 + 32'(v), 32'hA1000000 + 32'(v), 32'hA0000000 + 32'(v)},
                      tbl[v].exp, $sformatf("grant_vec%0d", v));
            pos();
        end
        bus.req_valid = 3'b000;
        neg();
        pos();
        neg();
        pos();
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
